pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequences the fetch PC of the static 5-stage pipeline.
- Arbitrates redirect requests from three sources:
  - the ID-stage branch resolver (taken flag plus target, in imem-relative addresses)
  - exception entry
  - ERET
- Holds a redirect that arrives during a hazard stall and applies it once the stall releases.
- Drives the IF/ID flush and optional redirect statistics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset (imem-relative).
- EXC_VECTOR, 32'h0000_0004, exception entry target (imem-relative).
- DELAY_SLOT, 1, 1 = branch/jump delay slot executes (no flush on branch redirect); 0 = flush the IF/ID slot on branch redirect.
- FLUSH_CYCLES, 1, cycles flush_ifid stays asserted per flushing redirect (range 1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit stall; PC and pending state must not advance
- br_taken  in  1  branch resolver: redirect required this cycle
- br_target  in  32  branch resolver target
- exc_req  in  1  exception entry request (1-cycle pulse)
- eret_req  in  1  ERET request (1-cycle pulse)
- epc  in  32  ERET return address
- pc  out  32  registered fetch PC
- flush_ifid  out  1  invalidate the IF/ID register this cycle
- redirect_pend  out  1  a redirect is latched and waiting on stall
- stat_br  out  32  taken-branch redirects applied (feature-gated)
- stat_held  out  32  redirects that waited on a stall (feature-gated)

Behaviour:
- Reset values, rst synchronous and dominant in every state:
  - pc=RESET_PC, state=RUN, pending cleared
  - flush_ifid=0, redirect_pend=0
  - stat_br=0, stat_held=0
- Source priority, combinational select: exc_req > eret_req > br_taken > sequential (pc+4).
  - Losing requests in the same cycle are dropped; upstream re-asserts them.
- Targets:
  - exc uses EXC_VECTOR.
  - eret uses epc.
  - branch uses br_target.
  - Wrap-around of pc+4 at 32'hFFFF_FFFC goes to 0; no error.
- States: RUN, HOLD, FLUSH.
- RUN:
  - stall=0, no request: pc<=pc+4.
  - stall=0, request: pc<=target in the next cycle (1-cycle latency).
    - If the request is flushing (exc, eret, or branch with DELAY_SLOT=0), go to FLUSH and load the flush counter with FLUSH_CYCLES.
    - Otherwise stay in RUN.
  - stall=1, no request: pc holds.
  - stall=1, request: latch target and flush-type into pending; redirect_pend=1; go to HOLD; pc holds.
- HOLD:
  - pc holds while stall=1.
  - A new request while in HOLD with strictly higher priority than the pending one replaces it. Equal or lower priority is dropped.
  - When stall falls: pc<=pending target, redirect_pend<=0, increment stat_held, then go to FLUSH if the pending redirect is flushing, else RUN.
- FLUSH:
  - flush_ifid=1 every cycle in FLUSH; the counter decrements only when stall=0.
  - pc advances sequentially (pc+4) when stall=0.
  - Leave to RUN when the counter reaches 1 with stall=0.
  - An exc_req in FLUSH is taken immediately: pc<=EXC_VECTOR and the counter reloads.
  - eret or branch requests in FLUSH are ignored; the flushed slot cannot raise them.
- flush_ifid is a registered output, asserted starting the cycle after the redirect cycle.
- stat_br increments when a branch redirect is applied to pc, whether direct or from HOLD. Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- Defined: stat_br and stat_held counters are built as described.
- Undefined: stat_br and stat_held are tied to 0, no counter flops, ports remain.

Decomposition:
- Shared package pc_ctrl_pkg:
  - state enum (RUN, HOLD, FLUSH)
  - redirect source encoding (SRC_NONE, SRC_BR, SRC_ERET, SRC_EXC) with ordered priority values
  - the 32'd4 PC increment constant
- One sub-module: redirect_arbiter.
  - Combinational priority select of source, target and flushing flag.
  - Reused for both the live request and the HOLD replacement compare.

Test Plan:
- Reset then 3 idle cycles with stall=0 -> pc sequence 0,4,8,12; flush_ifid=0 throughout.
- At pc=0x20, br_taken=1, br_target=0x100, DELAY_SLOT=1 -> next pc=0x100, no flush, stat_br=1.
- Same with DELAY_SLOT=0, FLUSH_CYCLES=2 -> pc=0x100, flush_ifid high 2 cycles, pc 0x104, 0x108.
- stall=1 for 3 cycles with br_taken=1 (target 0x80) in the first stall cycle:
  - pc holds and redirect_pend=1.
  - On stall release, pc=0x80 and stat_held=1.
- exc_req, eret_req and br_taken in the same cycle (epc=0x40) -> pc=EXC_VECTOR 0x4, flush asserted, branch dropped.
- In HOLD with pending branch, exc_req arrives -> pending replaced; pc=0x4 on stall release; rst asserted in HOLD -> pc=RESET_PC, redirect_pend=0 next cycle.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-PC redirect controller (package pc_ctrl_pkg).
// Source encodings are ordered so that a larger value always means a higher priority.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EXC  = 2'd3
  } src_e;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    src_e        src;
    logic [31:0] target;
    logic        flush;
  } redirect_t;

  localparam redirect_t NO_REDIRECT = '{src: SRC_NONE, target: 32'd0, flush: 1'b0};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Request/status bundle between the pipeline and the PC redirect controller.
// The pipeline side is the master; the controller is the slave.
interface pc_redirect_ctrl_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        flush_ifid;
  logic        redirect_pend;
  logic [31:0] stat_br;
  logic [31:0] stat_held;

  modport master (
    output stall, br_taken, br_target, exc_req, eret_req, epc,
    input  pc, flush_ifid, redirect_pend, stat_br, stat_held
  );

  modport slave (
    input  stall, br_taken, br_target, exc_req, eret_req, epc,
    output pc, flush_ifid, redirect_pend, stat_br, stat_held
  );
endinterface

// File: rtl/pc_redirect_ctrl_arbiter.sv
// Combinational priority select exc > eret > branch; produces source, target and flush flag.
// Zero latency; no backpressure of its own, losers are simply not reported.
module redirect_arbiter
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        br_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] br_target_i,
  output redirect_t   req_o
);

  always_comb begin
    req_o = NO_REDIRECT;
    if (exc_i) begin
      req_o.src    = SRC_EXC;
      req_o.target = EXC_VECTOR;
      req_o.flush  = 1'b1;
    end else if (eret_i) begin
      req_o.src    = SRC_ERET;
      req_o.target = epc_i;
      req_o.flush  = 1'b1;
    end else if (br_i) begin
      req_o.src    = SRC_BR;
      req_o.target = br_target_i;
      // With a delay slot the instruction behind the branch is architecturally live.
      req_o.flush  = !DELAY_SLOT;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: redirect arbitration, stall-held redirects, IF/ID flush, 1-cycle redirect latency.
// Stats counters exist only when PC_REDIRECT_STATS_EN is defined; otherwise stat outputs read 0.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter bit          DELAY_SLOT   = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  pc_redirect_ctrl_if.slave  bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  redirect_t   pend_q, pend_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        flush_q;
  redirect_t   live;
  redirect_t   eff;

  redirect_arbiter #(
    .EXC_VECTOR (EXC_VECTOR),
    .DELAY_SLOT (DELAY_SLOT)
  ) u_arb (
    .exc_i       (bus.exc_req),
    .eret_i      (bus.eret_req),
    .br_i        (bus.br_taken),
    .epc_i       (bus.epc),
    .br_target_i (bus.br_target),
    .req_o       (live)
  );

  // Only a strictly higher-priority live request displaces the held one.
  assign eff = (live.src > pend_q.src) ? live : pend_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (live.src != SRC_NONE) begin
            pc_d = live.target;
            if (live.flush) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_LOAD;
            end
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else if (live.src != SRC_NONE) begin
          pend_d  = live;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          pc_d    = eff.target;
          pend_d  = NO_REDIRECT;
          state_d = eff.flush ? FLUSH : RUN;
          if (eff.flush) cnt_d = FLUSH_LOAD;
        end else begin
          pend_d = eff;
        end
      end
      FLUSH: begin
        // Only exceptions are honoured here; eret/branch cannot come from a flushed slot.
        if (!bus.stall) begin
          if (live.src == SRC_EXC) begin
            pc_d  = live.target;
            cnt_d = FLUSH_LOAD;
          end else begin
            pc_d = pc_q + PC_INC;
            if (cnt_q == 2'd1) state_d = RUN;
            else               cnt_d   = cnt_q - 2'd1;
          end
        end else if (live.src == SRC_EXC) begin
          pend_d  = live;
          state_d = HOLD;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= NO_REDIRECT;
      cnt_q   <= 2'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      flush_q <= (state_d == FLUSH);
    end
  end

  assign bus.pc            = pc_q;
  assign bus.flush_ifid    = flush_q;
  assign bus.redirect_pend = (state_q == HOLD);

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] stat_br_q, stat_held_q;
  logic        br_applied, held_applied;

  assign held_applied = (state_q == HOLD) && !bus.stall;
  assign br_applied   = (!bus.stall && (state_q == RUN)  && (live.src == SRC_BR)) ||
                        (held_applied && (eff.src == SRC_BR));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q   <= 32'd0;
      stat_held_q <= 32'd0;
    end else begin
      if (br_applied)   stat_br_q   <= sat_inc(stat_br_q);
      if (held_applied) stat_held_q <= sat_inc(stat_held_q);
    end
  end

  assign bus.stat_br   = stat_br_q;
  assign bus.stat_held = stat_held_q;
`else
  assign bus.stat_br   = 32'd0;
  assign bus.stat_held = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench: delay-slot instance driven from a vector table, flushing instance by hand sequence.
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_redirect_ctrl_if ifa ();
  pc_redirect_ctrl_if ifb ();

  pc_redirect_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0004),
    .DELAY_SLOT   (1'b1),
    .FLUSH_CYCLES (1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  pc_redirect_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0004),
    .DELAY_SLOT   (1'b0),
    .FLUSH_CYCLES (2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, br, exc, eret;
    logic [31:0] tgt, epc;
    logic [31:0] e_pc;
    logic        e_fl, e_pend;
    logic [31:0] e_sb, e_sh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic x, logic e,
                              logic [31:0] t, logic [31:0] ep, logic [31:0] p,
                              logic f, logic pd, logic [31:0] sb, logic [31:0] sh);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.exc = x; v.eret = e;
    v.tgt = t; v.epc = ep; v.e_pc = p; v.e_fl = f; v.e_pend = pd;
    v.e_sb = STATS ? sb : 32'd0;
    v.e_sh = STATS ? sh : 32'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic s, input logic b, input logic x, input logic e,
                         input logic [31:0] t, input logic [31:0] ep);
    ifa.stall = s; ifa.br_taken = b; ifa.exc_req = x; ifa.eret_req = e;
    ifa.br_target = t; ifa.epc = ep;
  endtask

  task automatic drive_b(input logic b, input logic x, input logic [31:0] t);
    ifb.stall = 1'b0; ifb.br_taken = b; ifb.exc_req = x; ifb.eret_req = 1'b0;
    ifb.br_target = t; ifb.epc = 32'd0;
  endtask

  task automatic step_b(input string name, input logic [31:0] e_pc, input logic e_fl);
    @(posedge clk); #1;
    chk({name, ".pc"}, ifb.pc, e_pc);
    chk({name, ".flush"}, {31'd0, ifb.flush_ifid}, {31'd0, e_fl});
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_b(1'b0, 1'b0, 32'd0);

    //               rst  stl  br   exc  eret tgt            epc       pc            fl   pend sb  sh
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h4,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h8,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'hC,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h10,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h14,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h18,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h1C,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h20,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h100,       32'h0,  32'h100,       0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h104,       0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h80,        32'h0,  32'h104,       0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         32'h0,  32'h104,       0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         32'h0,  32'h104,       0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h80,        0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h84,        0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h200,       32'h40, 32'h4,         1, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h8,         0, 0, 2, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h300,       32'h0,  32'h8,         0, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         32'h0,  32'h8,         0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h4,         1, 0, 2, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h500,       32'h0,  32'h4,         1, 0, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h8,         0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h600,       32'h0,  32'h8,         0, 1, 2, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h600,       32'h0,  32'h0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h4,         0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,         32'h40, 32'h4,         0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h700,       32'h0,  32'h4,         0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h40,        1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h44,        0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,  32'hFFFF_FFF8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'hFFFF_FFFC, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0,         0, 0, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst;
      drive_a(vecs[i].stall, vecs[i].br, vecs[i].exc, vecs[i].eret, vecs[i].tgt, vecs[i].epc);
      @(posedge clk); #1;
      chk($sformatf("v%0d.pc", i), ifa.pc, vecs[i].e_pc);
      chk($sformatf("v%0d.flush", i), {31'd0, ifa.flush_ifid}, {31'd0, vecs[i].e_fl});
      chk($sformatf("v%0d.pend", i), {31'd0, ifa.redirect_pend}, {31'd0, vecs[i].e_pend});
      chk($sformatf("v%0d.stat_br", i), ifa.stat_br, vecs[i].e_sb);
      chk($sformatf("v%0d.stat_held", i), ifa.stat_held, vecs[i].e_sh);
    end
    rst_a = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Flushing instance: branch flushes for two cycles, then an exception inside FLUSH reloads the counter.
    rst_b = 1'b1;
    step_b("b.reset", 32'h0, 1'b0);
    rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    chk("b.pre_br.pc", ifb.pc, 32'h20);
    drive_b(1'b1, 1'b0, 32'h100);
    step_b("b.br", 32'h100, 1'b1);
    drive_b(1'b0, 1'b0, 32'h0);
    step_b("b.fl1", 32'h104, 1'b1);
    step_b("b.fl2", 32'h108, 1'b0);
    chk("b.stat_br", ifb.stat_br, STATS ? 32'd1 : 32'd0);
    drive_b(1'b1, 1'b0, 32'h200);
    step_b("b.br2", 32'h200, 1'b1);
    drive_b(1'b0, 1'b1, 32'h0);
    step_b("b.exc_in_flush", 32'h4, 1'b1);
    drive_b(1'b0, 1'b0, 32'h0);
    step_b("b.reload1", 32'h8, 1'b1);
    step_b("b.reload2", 32'hC, 1'b0);
    step_b("b.run", 32'h10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
